// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Function : Hazard/forwarding control, syscall-halt FSM and perf counters for
//            the 5-stage MIPS pipeline.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int ENABLE_FWD = 1,
    parameter int COUNT_W    = 32
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [4:0]         ID_rs,
    input  logic [4:0]         ID_rt,
    input  logic               ID_R1_used,
    input  logic               ID_R2_used,
    input  logic [4:0]         EX_Write_Reg,
    input  logic               EX_Regwrite,
    input  logic               EX_Memtoreg,
    input  logic [4:0]         MEM_Write_Reg,
    input  logic               MEM_Regwrite,
    input  logic               EX_taken,
    input  logic               EX_Syscall,
    input  logic               EX_halt,
    input  logic               go,
    output logic               PC_Enable,
    output logic               IF_ID_Enable,
    output logic               IF_ID_clr,
    output logic               ID_EX_Enable,
    output logic               ID_EX_clr,
    output logic [1:0]         conflict_A,
    output logic [1:0]         conflict_B,
    output logic               halted,
    output logic [COUNT_W-1:0] cycle_count,
    output logic [COUNT_W-1:0] stall_count,
    output logic [COUNT_W-1:0] flush_count
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t             state_q;
    logic               go_q;
    logic [COUNT_W-1:0] cycle_count_q;
    logic [COUNT_W-1:0] stall_count_q;
    logic [COUNT_W-1:0] flush_count_q;

    logic       w_rs_ex;
    logic       w_rs_mem;
    logic       w_rt_ex;
    logic       w_rt_mem;
    logic       w_stall;
    logic       w_sys_halt;
    logic       w_go_rise;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    assign w_rs_ex  = ID_R1_used & EX_Regwrite  & (EX_Write_Reg  == ID_rs) & (ID_rs != 5'd0);
    assign w_rs_mem = ID_R1_used & MEM_Regwrite & (MEM_Write_Reg == ID_rs) & (ID_rs != 5'd0);
    assign w_rt_ex  = ID_R2_used & EX_Regwrite  & (EX_Write_Reg  == ID_rt) & (ID_rt != 5'd0);
    assign w_rt_mem = ID_R2_used & MEM_Regwrite & (MEM_Write_Reg == ID_rt) & (ID_rt != 5'd0);

    assign w_sys_halt = EX_Syscall & EX_halt;
    assign w_go_rise  = go & ~go_q;

    // Without forwarding every RAW dependence must wait for writeback.
    generate
        if (ENABLE_FWD != 0) begin : g_fwd
            assign w_stall = EX_Memtoreg & (w_rs_ex | w_rt_ex);
            assign w_fwd_a = w_rs_ex ? 2'd1 : (w_rs_mem ? 2'd2 : 2'd0);
            assign w_fwd_b = w_rt_ex ? 2'd1 : (w_rt_mem ? 2'd2 : 2'd0);
        end else begin : g_nofwd
            assign w_stall = w_rs_ex | w_rs_mem | w_rt_ex | w_rt_mem | (EX_Memtoreg & 1'b0);
            assign w_fwd_a = 2'd0;
            assign w_fwd_b = 2'd0;
        end
    endgenerate

    always_comb begin
        PC_Enable    = 1'b1;
        IF_ID_Enable = 1'b1;
        IF_ID_clr    = 1'b0;
        ID_EX_Enable = 1'b1;
        ID_EX_clr    = 1'b0;
        conflict_A   = 2'd0;
        conflict_B   = 2'd0;
        halted       = 1'b0;
        if (clr) begin
            PC_Enable    = 1'b0;
            IF_ID_Enable = 1'b0;
            IF_ID_clr    = 1'b1;
            ID_EX_clr    = 1'b1;
        end else if (state_q == ST_HALT) begin
            PC_Enable    = 1'b0;
            IF_ID_Enable = 1'b0;
            ID_EX_Enable = 1'b0;
            halted       = 1'b1;
        end else if (EX_taken) begin
            IF_ID_clr    = 1'b1;
            ID_EX_clr    = 1'b1;
        end else if (w_sys_halt || w_stall) begin
            PC_Enable    = 1'b0;
            IF_ID_Enable = 1'b0;
            ID_EX_clr    = 1'b1;
        end else begin
            conflict_A   = w_fwd_a;
            conflict_B   = w_fwd_b;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= ST_RUN;
            go_q          <= 1'b0;
            cycle_count_q <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            go_q <= go;
            if (state_q == ST_RUN) begin
                cycle_count_q <= cycle_count_q + COUNT_W'(1);
                if (EX_taken) begin
                    flush_count_q <= flush_count_q + COUNT_W'(1);
                end else if (w_sys_halt) begin
                    state_q <= ST_HALT;
                end else if (w_stall) begin
                    stall_count_q <= stall_count_q + COUNT_W'(1);
                end
            end else if (w_go_rise) begin
                state_q <= ST_RUN;
            end
        end
    end

    assign cycle_count = cycle_count_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Function : Directed plus random checks of hazard_ctrl, forwarding and
//            non-forwarding builds, against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr;
    logic [4:0] ID_rs, ID_rt, EX_Write_Reg, MEM_Write_Reg;
    logic       ID_R1_used, ID_R2_used, EX_Regwrite, EX_Memtoreg, MEM_Regwrite;
    logic       EX_taken, EX_Syscall, EX_halt, go;

    logic        pc_f, ifen_f, ifclr_f, exen_f, exclr_f, halted_f;
    logic [1:0]  ca_f, cb_f;
    logic [31:0] cyc_f, stl_f, fls_f;
    logic        pc_n, ifen_n, ifclr_n, exen_n, exclr_n, halted_n;
    logic [1:0]  ca_n, cb_n;
    logic [7:0]  cyc_n, stl_n, fls_n;

    hazard_ctrl #(.ENABLE_FWD(1), .COUNT_W(32)) u_fwd (
        .clk(clk), .clr(clr), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_R1_used(ID_R1_used), .ID_R2_used(ID_R2_used),
        .EX_Write_Reg(EX_Write_Reg), .EX_Regwrite(EX_Regwrite), .EX_Memtoreg(EX_Memtoreg),
        .MEM_Write_Reg(MEM_Write_Reg), .MEM_Regwrite(MEM_Regwrite),
        .EX_taken(EX_taken), .EX_Syscall(EX_Syscall), .EX_halt(EX_halt), .go(go),
        .PC_Enable(pc_f), .IF_ID_Enable(ifen_f), .IF_ID_clr(ifclr_f),
        .ID_EX_Enable(exen_f), .ID_EX_clr(exclr_f),
        .conflict_A(ca_f), .conflict_B(cb_f), .halted(halted_f),
        .cycle_count(cyc_f), .stall_count(stl_f), .flush_count(fls_f)
    );

    hazard_ctrl #(.ENABLE_FWD(0), .COUNT_W(8)) u_nofwd (
        .clk(clk), .clr(clr), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_R1_used(ID_R1_used), .ID_R2_used(ID_R2_used),
        .EX_Write_Reg(EX_Write_Reg), .EX_Regwrite(EX_Regwrite), .EX_Memtoreg(EX_Memtoreg),
        .MEM_Write_Reg(MEM_Write_Reg), .MEM_Regwrite(MEM_Regwrite),
        .EX_taken(EX_taken), .EX_Syscall(EX_Syscall), .EX_halt(EX_halt), .go(go),
        .PC_Enable(pc_n), .IF_ID_Enable(ifen_n), .IF_ID_clr(ifclr_n),
        .ID_EX_Enable(exen_n), .ID_EX_clr(exclr_n),
        .conflict_A(ca_n), .conflict_B(cb_n), .halted(halted_n),
        .cycle_count(cyc_n), .stall_count(stl_n), .flush_count(fls_n)
    );

    int passes = 0;
    int total  = 0;

    // Model state, index 0 = forwarding build, 1 = non-forwarding build
    bit          m_halt [2];
    bit          m_go   [2];
    longint      m_cyc  [2];
    longint      m_stl  [2];
    longint      m_fls  [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic idle();
        clr = 1'b0; ID_rs = 5'd0; ID_rt = 5'd0; ID_R1_used = 1'b0; ID_R2_used = 1'b0;
        EX_Write_Reg = 5'd0; EX_Regwrite = 1'b0; EX_Memtoreg = 1'b0;
        MEM_Write_Reg = 5'd0; MEM_Regwrite = 1'b0;
        EX_taken = 1'b0; EX_Syscall = 1'b0; EX_halt = 1'b0;
    endtask

    // Compare both builds against the model, then advance one clock.
    task automatic step();
        bit     hz [2];
        bit     rs_ex, rs_mem, rt_ex, rt_mem;
        bit     e_pc, e_ifen, e_ifclr, e_exen, e_exclr, e_halt, conf_ok;
        logic [1:0]  e_ca, e_cb;
        logic [63:0] mask;
        #1;
        rs_ex  = ID_R1_used && EX_Regwrite  && EX_Write_Reg  == ID_rs && ID_rs != 0;
        rs_mem = ID_R1_used && MEM_Regwrite && MEM_Write_Reg == ID_rs && ID_rs != 0;
        rt_ex  = ID_R2_used && EX_Regwrite  && EX_Write_Reg  == ID_rt && ID_rt != 0;
        rt_mem = ID_R2_used && MEM_Regwrite && MEM_Write_Reg == ID_rt && ID_rt != 0;
        hz[0] = EX_Memtoreg && (rs_ex || rt_ex);
        hz[1] = rs_ex || rs_mem || rt_ex || rt_mem;
        for (int k = 0; k < 2; k++) begin
            mask = (k == 0) ? 64'hFFFF_FFFF : 64'hFF;
            conf_ok = 1'b1; e_ca = 2'd0; e_cb = 2'd0;
            if (clr)                         {e_pc, e_ifen, e_ifclr, e_exen, e_exclr, e_halt} = 6'b001110;
            else if (m_halt[k])              {e_pc, e_ifen, e_ifclr, e_exen, e_exclr, e_halt} = 6'b000001;
            else if (EX_taken)               {e_pc, e_ifen, e_ifclr, e_exen, e_exclr, e_halt} = 6'b111110;
            else if (EX_Syscall && EX_halt) begin
                {e_pc, e_ifen, e_ifclr, e_exen, e_exclr, e_halt} = 6'b000110;
                conf_ok = 1'b0;
            end
            else if (hz[k])                  {e_pc, e_ifen, e_ifclr, e_exen, e_exclr, e_halt} = 6'b000110;
            else begin
                {e_pc, e_ifen, e_ifclr, e_exen, e_exclr, e_halt} = 6'b110100;
                if (k == 0) begin
                    e_ca = rs_ex ? 2'd1 : (rs_mem ? 2'd2 : 2'd0);
                    e_cb = rt_ex ? 2'd1 : (rt_mem ? 2'd2 : 2'd0);
                end
            end
            if (k == 0) begin
                chk("ctl_f", {pc_f, ifen_f, ifclr_f, exen_f, exclr_f, halted_f},
                    {e_pc, e_ifen, e_ifclr, e_exen, e_exclr, e_halt});
                if (conf_ok) chk("conf_f", {ca_f, cb_f}, {e_ca, e_cb});
                chk("cyc_f", cyc_f, m_cyc[0] & mask);
                chk("stl_f", stl_f, m_stl[0] & mask);
                chk("fls_f", fls_f, m_fls[0] & mask);
            end else begin
                chk("ctl_n", {pc_n, ifen_n, ifclr_n, exen_n, exclr_n, halted_n},
                    {e_pc, e_ifen, e_ifclr, e_exen, e_exclr, e_halt});
                if (conf_ok) chk("conf_n", {ca_n, cb_n}, {e_ca, e_cb});
                chk("cyc_n", cyc_n, m_cyc[1] & mask);
                chk("stl_n", stl_n, m_stl[1] & mask);
                chk("fls_n", fls_n, m_fls[1] & mask);
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                m_halt[k] = 0; m_go[k] = 0; m_cyc[k] = 0; m_stl[k] = 0; m_fls[k] = 0;
            end else begin
                if (!m_halt[k]) begin
                    m_cyc[k]++;
                    if (EX_taken) m_fls[k]++;
                    else if (EX_Syscall && EX_halt) m_halt[k] = 1;
                    else if (hz[k]) m_stl[k]++;
                end else if (go && !m_go[k]) begin
                    m_halt[k] = 0;
                end
                m_go[k] = go;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_halt[k] = 0; m_go[k] = 0; m_cyc[k] = 0; m_stl[k] = 0; m_fls[k] = 0;
        end
        idle(); go = 1'b0; clr = 1'b1;
        @(negedge clk);

        // Reset
        step(); step();
        #1 chk("rst_halted", halted_f, 0);
        chk("rst_ifclr", ifclr_f, 1);
        chk("rst_cyc", cyc_f, 0);
        clr = 1'b0;
        step(); step(); step();
        #1 chk("run_cyc3", cyc_f, 3);
        chk("run_pc", pc_f, 1);

        // Forwarding priority
        ID_rs = 5'd5; ID_R1_used = 1'b1; EX_Regwrite = 1'b1; EX_Write_Reg = 5'd5;
        MEM_Write_Reg = 5'd5; MEM_Regwrite = 1'b1;
        #1 chk("fwd_ex", ca_f, 1);
        step();
        EX_Regwrite = 1'b0;
        #1 chk("fwd_mem", ca_f, 2);
        step();
        ID_rs = 5'd0;
        #1 chk("fwd_r0", ca_f, 0);
        step();

        // Load-use: one bubble then MEM forward
        idle(); EX_Memtoreg = 1'b1; EX_Regwrite = 1'b1; EX_Write_Reg = 5'd8;
        ID_rt = 5'd8; ID_R2_used = 1'b1;
        #1 chk("lu_pc", pc_f, 0);
        chk("lu_cb", cb_f, 0);
        step();
        EX_Memtoreg = 1'b0; EX_Regwrite = 1'b0; MEM_Write_Reg = 5'd8; MEM_Regwrite = 1'b1;
        #1 chk("lu_cb_mem", cb_f, 2);
        chk("lu_stl", stl_f, 1);
        step();

        // Flush beats stall
        idle(); EX_Memtoreg = 1'b1; EX_Regwrite = 1'b1; EX_Write_Reg = 5'd8;
        ID_rt = 5'd8; ID_R2_used = 1'b1; EX_taken = 1'b1;
        #1 chk("fl_ifclr", ifclr_f, 1);
        chk("fl_pc", pc_f, 1);
        step();
        idle();
        #1 chk("fl_cnt", fls_f, 1);
        chk("fl_stl", stl_f, 1);

        // Halt with go held, then resume on a fresh rising edge
        go = 1'b1; EX_Syscall = 1'b1; EX_halt = 1'b1;
        step();
        idle();
        #1 chk("h_halted", halted_f, 1);
        step(); step();
        #1 chk("h_still", halted_f, 1);
        chk("h_cyc", cyc_f, m_cyc[0]);
        go = 1'b0; step();
        go = 1'b1; step();
        #1 chk("h_resume", halted_f, 0);

        // Non-forwarding: MEM match stalls every cycle
        clr = 1'b1; step(); idle();
        ID_rs = 5'd3; ID_R1_used = 1'b1; MEM_Regwrite = 1'b1; MEM_Write_Reg = 5'd3;
        step(); step(); step();
        #1 chk("nf_ca", ca_n, 0);
        MEM_Regwrite = 1'b0;
        #1 chk("nf_stl", stl_n, 3);
        step();

        // Counter wrap in the 8-bit build
        idle();
        for (int i = 0; i < 260; i++) step();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            clr           = ($urandom_range(0, 299) == 0);
            ID_rs         = 5'($urandom_range(0, 3));
            ID_rt         = 5'($urandom_range(0, 3));
            ID_R1_used    = 1'($urandom_range(0, 1));
            ID_R2_used    = 1'($urandom_range(0, 1));
            EX_Write_Reg  = 5'($urandom_range(0, 3));
            EX_Regwrite   = 1'($urandom_range(0, 1));
            EX_Memtoreg   = ($urandom_range(0, 2) == 0);
            MEM_Write_Reg = 5'($urandom_range(0, 3));
            MEM_Regwrite  = 1'($urandom_range(0, 1));
            EX_taken      = ($urandom_range(0, 9) == 0);
            EX_Syscall    = ($urandom_range(0, 19) == 0);
            EX_halt       = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) go = ~go;
            step();
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

`default_nettype wire
